simon_display_reader: RTL and testbench
=======================================

# simon_display_reader

- Decodes the Simon game's multiplexed two-digit 7-segment output (`seg`, `dig1`, `dig2`) back into hex digit values.
- Serves as the display-side counterpart of the game core: used in the bench and in on-chip self-check to read the displayed score without a segment-by-segment model.
- Filters multiplex glitches with a stability counter and latches each digit per refresh.
- Flags illegal segment patterns and reports value changes.

## Interface

Parameters:
- `STABLE_CYCLES`, 8: consecutive identical samples required before a digit is captured (≥2).
- `TIMEOUT_CYCLES`, 65536: refresh watchdog period (only with `DISPLAY_READER_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `seg` in 7: segment lines, bit0=a … bit6=g.
- `dig1` in 1: tens-digit select.
- `dig2` in 1: ones-digit select.
- `seginv` in 1: when 1, `seg`, `dig1` and `dig2` are active-low; otherwise all are active-high.
- `d1_code` out 4: tens digit value 0–F.
- `d1_blank` out 1: tens digit shows all segments off.
- `d1_err` out 1: tens digit shows a non-hex pattern.
- `d2_code`, `d2_blank`, `d2_err`: same three outputs for the ones digit.
- `valid` out 1: both digits captured at least once.
- `update` out 1: one-cycle pulse when any captured digit field changes.

## Operation

- **Input stage:** inputs are registered once, then XORed with `seginv` to normalise to active-high.
- **Normalised selection:**
  - `sel` = 1 when exactly one of the normalised digit selects is high.
  - `sel` = 0 when neither or both are high.
- **FSM states:**
  - **IDLE:** `sel`=0. Counter cleared. When `sel`=1, go to TRACK with count=1.
  - **TRACK:**
    - Sample identical to previous (same digit, same pattern): count++.
    - Pattern or digit changed while still `sel`: count=1, stay in TRACK.
    - `sel`=0: go to IDLE, nothing captured.
    - count reaches `STABLE_CYCLES`: capture into the active digit's registers, go to HOLD.
  - **HOLD:**
    - Sample identical: stay, no further capture.
    - `sel`=0: go to IDLE.
    - Different pattern or digit with `sel`=1: go to TRACK with count=1. A new capture is then allowed.
- **Decode (normalised `seg` hex):**
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - A:77, b:7C, C:39, d:5E, E:79, F:71.
  - 00 → blank=1, code=0, err=0.
  - Any other pattern → err=1, code=0, blank=0.
- **Captured fields:** each digit captures {code, blank, err} together.
- **`update`:** pulses the cycle after a capture whose fields differ from that digit's previous fields. The first capture of each digit after reset always pulses.
- **`valid`:** a sticky bit per digit; `valid` is the AND of both.
- **`seginv` changing mid-run:** treated as a pattern change, so TRACK restarts.
- **Counter:** width $clog2(STABLE_CYCLES+1). It saturates and never wraps.

## Timing

- **Reset (synchronous):**
  - All outputs 0, state IDLE, counter 0, sticky bits 0.
  - Input register cleared to 0 (raw, pre-inversion).
- **Latency:** an input held from edge N is sampled at N+1. The capture edge is N+`STABLE_CYCLES`. Outputs and `update` are visible after that edge.
- **Glitch rejection:** a pattern shorter than `STABLE_CYCLES` samples is never captured.
- **Digit switch without blanking:** `dig1`→`dig2` switching directly restarts TRACK with no gap cycle needed.
- **Both digits selected:** treated as IDLE. Captured values are held.
- **`rst_n` low mid-TRACK:** the capture is discarded and all outputs return to reset values on that edge.

## Configuration

- **`DISPLAY_READER_TIMEOUT_EN` defined:**
  - A per-digit watchdog counts cycles since that digit's last capture or re-confirmation.
  - Re-confirmation means HOLD state with that digit selected. The count resets on every such cycle.
  - At `TIMEOUT_CYCLES` the digit's sticky valid bit clears and its fields reset to 0. `update` pulses once.
- **Macro undefined:**
  - No watchdog logic.
  - Captured values and `valid` persist until reset.

## Test plan

All scenarios use STABLE_CYCLES=4, seginv=0.

- **Basic capture:** reset, then dig1=1, seg=0x06 for 10 cycles, then dig2=1, seg=0x5B for 10 cycles.
  - d1_code=1, d2_code=2, valid=1.
  - Exactly two `update` pulses, each 4 cycles after its digit's first sampled edge.
- **Glitch rejection:** dig1=1, seg=0x7F for 3 cycles, then seg=0x3F for 6 cycles.
  - d1_code=0, never 8.
  - One `update` pulse.
- **Inverted polarity:** seginv=1, dig2=0 (raw), dig1=1 (raw), seg=~0x6D for 8 cycles.
  - d2_code=5.
  - d1 unchanged.
- **Blank and error:**
  - dig1 with seg=0x00 → d1_blank=1, d1_err=0.
  - Then seg=0x01 → d1_err=1, d1_code=0.
- **Refresh without change:** re-present the same d1 value across 5 multiplex periods.
  - Only the first capture pulses `update`.
- **Reset and timeout:**
  - Assert rst_n=0 on cycle 3 of TRACK → all outputs 0 on the next edge.
  - With `DISPLAY_READER_TIMEOUT_EN` and TIMEOUT_CYCLES=32: after a capture, hold dig1=dig2=0 for 32 cycles → valid falls and one `update` pulse.

Source files
------------

// File: rtl/simon_display_reader.sv
// Recovers the two hex digits shown on the Simon game's multiplexed 7-segment display.
// Optional refresh watchdog: define DISPLAY_READER_TIMEOUT_EN.
module simon_display_reader #(
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic       dig1,
    input  logic       dig2,
    input  logic       seginv,
    output logic [3:0] d1_code,
    output logic       d1_blank,
    output logic       d1_err,
    output logic [3:0] d2_code,
    output logic       d2_blank,
    output logic       d2_err,
    output logic       valid,
    output logic       update
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);

    if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("simon_display_reader: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]       seg_q;
    logic             dig1_q, dig2_q, seginv_q;
    logic [6:0]       seg_n;
    logic             d1_n, d2_n, sel, same, capture;
    logic [8:0]       key, key_q;
    logic [3:0]       dec_code;
    logic             dec_blank, dec_err;
    logic [5:0]       new_f, d1_f_q, d2_f_q;
    logic             v1_q, v2_q, update_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= '0;
            dig1_q   <= 1'b0;
            dig2_q   <= 1'b0;
            seginv_q <= 1'b0;
        end else begin
            seg_q    <= seg;
            dig1_q   <= dig1;
            dig2_q   <= dig2;
            seginv_q <= seginv;
        end
    end

    assign seg_n = seg_q ^ {7{seginv_q}};
    assign d1_n  = dig1_q ^ seginv_q;
    assign d2_n  = dig2_q ^ seginv_q;
    assign sel   = d1_n ^ d2_n;
    // Polarity is part of the sample identity so a seginv flip restarts tracking.
    assign key   = {seginv_q, d2_n, seg_n};
    assign same  = (key == key_q);

    always_comb begin
        dec_code  = '0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_n)
            7'h3F: dec_code = 4'h0;
            7'h06: dec_code = 4'h1;
            7'h5B: dec_code = 4'h2;
            7'h4F: dec_code = 4'h3;
            7'h66: dec_code = 4'h4;
            7'h6D: dec_code = 4'h5;
            7'h7D: dec_code = 4'h6;
            7'h07: dec_code = 4'h7;
            7'h7F: dec_code = 4'h8;
            7'h6F: dec_code = 4'h9;
            7'h77: dec_code = 4'hA;
            7'h7C: dec_code = 4'hB;
            7'h39: dec_code = 4'hC;
            7'h5E: dec_code = 4'hD;
            7'h79: dec_code = 4'hE;
            7'h71: dec_code = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign new_f = {dec_code, dec_blank, dec_err};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            TRACK: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_STABLE) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sel) begin
                key_q <= key;
            end
        end
    end

`ifdef DISPLAY_READER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd1_q, wd2_q;
    logic            cap1, cap2, conf1, conf2, expire1, expire2;

    assign cap1    = capture && !d2_n;
    assign cap2    = capture && d2_n;
    assign conf1   = (state_q == HOLD) && !key_q[7];
    assign conf2   = (state_q == HOLD) && key_q[7];
    assign expire1 = v1_q && !cap1 && !conf1 && (wd1_q == WD_LAST);
    assign expire2 = v2_q && !cap2 && !conf2 && (wd2_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd1_q <= '0;
            wd2_q <= '0;
        end else begin
            wd1_q <= (cap1 || conf1 || !v1_q || expire1) ? '0 : wd1_q + WD_W'(1);
            wd2_q <= (cap2 || conf2 || !v2_q || expire2) ? '0 : wd2_q + WD_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_f_q   <= '0;
            d2_f_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            update_q <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (capture && !d2_n) begin
                d1_f_q <= new_f;
                v1_q   <= 1'b1;
                if (!v1_q || d1_f_q != new_f) begin
                    update_q <= 1'b1;
                end
            end
            if (capture && d2_n) begin
                d2_f_q <= new_f;
                v2_q   <= 1'b1;
                if (!v2_q || d2_f_q != new_f) begin
                    update_q <= 1'b1;
                end
            end
`ifdef DISPLAY_READER_TIMEOUT_EN
            if (expire1) begin
                d1_f_q   <= '0;
                v1_q     <= 1'b0;
                update_q <= 1'b1;
            end
            if (expire2) begin
                d2_f_q   <= '0;
                v2_q     <= 1'b0;
                update_q <= 1'b1;
            end
`endif
        end
    end

    assign {d1_code, d1_blank, d1_err} = d1_f_q;
    assign {d2_code, d2_blank, d2_err} = d2_f_q;
    assign valid  = v1_q & v2_q;
    assign update = update_q;

endmodule

// File: tb/tb_simon_display_reader.sv
// Directed self-checking bench for simon_display_reader with STABLE_CYCLES=4.
// Watchdog scenario is exercised only when DISPLAY_READER_TIMEOUT_EN is defined.
module tb_simon_display_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       dig1, dig2, seginv;
    logic [3:0] d1_code, d2_code;
    logic       d1_blank, d1_err, d2_blank, d2_err, valid, update;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;
    bit saw8     = 1'b0;

    simon_display_reader #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .dig1    (dig1),
        .dig2    (dig2),
        .seginv  (seginv),
        .d1_code (d1_code),
        .d1_blank(d1_blank),
        .d1_err  (d1_err),
        .d2_code (d2_code),
        .d2_blank(d2_blank),
        .d2_err  (d2_err),
        .valid   (valid),
        .update  (update)
    );

    always #5 clk = ~clk;

    // update is a full-cycle pulse, so each one is seen at exactly one falling edge
    always @(negedge clk) begin
        if (update) upd_cnt++;
        if (d1_code == 4'h8) saw8 = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic d1, input logic d2, input logic [6:0] s, input logic inv);
        @(negedge clk);
        dig1   = d1;
        dig2   = d2;
        seg    = s;
        seginv = inv;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_d1_code"}, 32'(d1_code), 0);
        check_eq({tag, "_d1_blank"}, 32'(d1_blank), 0);
        check_eq({tag, "_d1_err"}, 32'(d1_err), 0);
        check_eq({tag, "_d2_code"}, 32'(d2_code), 0);
        check_eq({tag, "_d2_blank"}, 32'(d2_blank), 0);
        check_eq({tag, "_d2_err"}, 32'(d2_err), 0);
        check_eq({tag, "_valid"}, 32'(valid), 0);
        check_eq({tag, "_update"}, 32'(update), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int n;

        // Reset with a live-looking display on the inputs: nothing may leak through.
        rst_n = 1'b0; dig1 = 1'b1; dig2 = 1'b0; seg = 7'h06; seginv = 1'b0;
        cycles(6);
        check_all_zero("reset");
        drive(0, 0, 7'h00, 0);
        rst_n = 1'b1;
        cycles(2);

        // Basic capture: capture lands on the 4th edge after the register edge.
        drive(1, 0, 7'h06, 0);
        cycles(4);
        check_eq("basic1_pre_update", 32'(update), 0);
        check_eq("basic1_pre_code", 32'(d1_code), 0);
        cycles(1);
        check_eq("basic1_update", 32'(update), 1);
        check_eq("basic1_code", 32'(d1_code), 1);
        check_eq("basic1_valid", 32'(valid), 0);
        cycles(5);
        drive(0, 1, 7'h5B, 0);
        cycles(4);
        check_eq("basic2_pre_update", 32'(update), 0);
        cycles(1);
        check_eq("basic2_update", 32'(update), 1);
        check_eq("basic2_code", 32'(d2_code), 2);
        check_eq("basic2_d1_code", 32'(d1_code), 1);
        check_eq("basic2_valid", 32'(valid), 1);
        cycles(5);
        check_eq("basic_update_count", 32'(upd_cnt), 2);

        // Glitch rejection: 3 samples of '8' must never be captured.
        base = upd_cnt;
        drive(1, 0, 7'h7F, 0);
        cycles(3);
        drive(1, 0, 7'h3F, 0);
        cycles(6);
        check_eq("glitch_code", 32'(d1_code), 0);
        check_eq("glitch_blank", 32'(d1_blank), 0);
        check_eq("glitch_err", 32'(d1_err), 0);
        check_eq("glitch_saw8", 32'(saw8), 0);
        check_eq("glitch_updates", 32'(upd_cnt - base), 1);

        // Inverted polarity: raw dig2=0/dig1=1 selects the ones digit; ~0x6D = 0x12.
        base = upd_cnt;
        drive(1, 0, 7'h12, 1);
        cycles(8);
        check_eq("inv_d2_code", 32'(d2_code), 5);
        check_eq("inv_d2_err", 32'(d2_err), 0);
        check_eq("inv_d1_code", 32'(d1_code), 0);
        check_eq("inv_updates", 32'(upd_cnt - base), 1);
        drive(0, 0, 7'h00, 0);
        cycles(2);

        // Blank then illegal pattern on the tens digit.
        base = upd_cnt;
        drive(1, 0, 7'h00, 0);
        cycles(6);
        check_eq("blank_blank", 32'(d1_blank), 1);
        check_eq("blank_err", 32'(d1_err), 0);
        check_eq("blank_code", 32'(d1_code), 0);
        drive(1, 0, 7'h01, 0);
        cycles(6);
        check_eq("err_err", 32'(d1_err), 1);
        check_eq("err_blank", 32'(d1_blank), 0);
        check_eq("err_code", 32'(d1_code), 0);
        check_eq("blank_err_updates", 32'(upd_cnt - base), 2);

        // Refresh without change: five multiplex periods of "35".
        base = upd_cnt;
        for (int p = 0; p < 5; p++) begin
            drive(1, 0, 7'h4F, 0);
            cycles(6);
            drive(0, 1, 7'h6D, 0);
            cycles(6);
        end
        check_eq("refresh_d1_code", 32'(d1_code), 3);
        check_eq("refresh_d2_code", 32'(d2_code), 5);
        check_eq("refresh_valid", 32'(valid), 1);
        check_eq("refresh_updates", 32'(upd_cnt - base), 1);

        // Both digits selected behaves as idle: captured values are held.
        base = upd_cnt;
        drive(1, 1, 7'h06, 0);
        cycles(8);
        check_eq("both_d1_code", 32'(d1_code), 3);
        check_eq("both_d2_code", 32'(d2_code), 5);
        check_eq("both_updates", 32'(upd_cnt - base), 0);

        drive(0, 0, 7'h00, 0);
`ifdef DISPLAY_READER_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (update) n++;
            if (!valid) break;
        end
        check_eq("timeout_valid", 32'(valid), 0);
        check_eq("timeout_updates", 32'(n), 1);
`else
        n = 0;
        cycles(60);
        check_eq("persist_valid", 32'(valid), 1);
        check_eq("persist_d1_code", 32'(d1_code), 3);
`endif

        // Reset on the third TRACK cycle discards the pending capture.
        drive(1, 0, 7'h07, 0);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b0;
        cycles(1);
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(8);
        check_eq("after_reset_d1_code", 32'(d1_code), 7);
        check_eq("after_reset_d2_code", 32'(d2_code), 0);
        check_eq("after_reset_valid", 32'(valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
